// File: rtl/cut_result_collector_pkg.sv
// Shared configuration, state encoding and record constants
// for the CUT result collector.
package cut_result_collector_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int N          = 32;
    localparam int DIG_BYTES  = N / 8;

    localparam logic [7:0] RECORD_HDR = 8'hA5;
    localparam logic [7:0] CRC_POLY   = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_SEND
    } state_t;

endpackage

// File: rtl/cut_result_collector_if.sv
// Byte-stream handshake between the collector and its consumer.
interface cut_result_collector_if;
    import cut_result_collector_pkg::*;

    logic       byte_rd;
    logic [7:0] byte_out;
    logic       byte_valid;

    modport master (input byte_rd, output byte_out, output byte_valid);
    modport slave (output byte_rd, input byte_out, input byte_valid);

endinterface

// File: rtl/cut_crc8.sv
// Running CRC-8 (MSB-first, init 0) over bytes fed one per enable.
module cut_crc8
    import cut_result_collector_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    function automatic logic [7:0] crc_step(input logic [7:0] c,
                                            input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++)
            x = x[7] ? ((x << 1) ^ CRC_POLY) : (x << 1);
        return x;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_crc <= 8'h00;
        else if (i_clr)
            r_crc <= 8'h00;
        else if (i_en)
            r_crc <= crc_step(r_crc, i_byte);
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/cut_result_collector.sv
// Drives one CUT run and streams back a result record byte by byte.
// Define CUT_RESULT_CRC_EN to append a CRC-8 trailer byte.
module cut_result_collector
    import cut_result_collector_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576,
    parameter int          HOLD_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  rst_cut,
    output logic [DATA_WIDTH-1:0] input_to_cut,
    input  logic                  end_cut,
    input  logic [N-1:0]          output_from_cut,
    cut_result_collector_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);

`ifdef CUT_RESULT_CRC_EN
    localparam int REC_LEN = 7 + DIG_BYTES;
`else
    localparam int REC_LEN = 6 + DIG_BYTES;
`endif
    localparam logic [7:0] LAST_IDX = 8'(REC_LEN - 1);
    localparam logic [7:0] DIG_END  = 8'(6 + DIG_BYTES);

    state_t                r_state;
    state_t                w_nstate;
    logic [DATA_WIDTH-1:0] r_in;
    logic [31:0]           r_cnt;
    logic [31:0]           r_hold;
    logic                  r_to;
    logic [N-1:0]          r_digest;
    logic [7:0]            r_idx;
    logic                  r_done;

    logic                  w_send;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_at_limit;
    logic [7:0]            w_byte;

    assign w_send     = (r_state == S_SEND);
    assign w_pop      = w_send && bus.byte_rd;
    assign w_last     = w_pop && (r_idx == LAST_IDX);
    assign w_at_limit = (r_cnt == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_nstate = S_LOAD;
            S_LOAD:    if (r_hold == 32'(HOLD_CYCLES - 1)) w_nstate = S_RUN;
            S_RUN:     if (end_cut || w_at_limit) w_nstate = S_CAPTURE;
            S_CAPTURE: w_nstate = S_SEND;
            S_SEND:    if (w_last) w_nstate = S_IDLE;
            default:   w_nstate = S_IDLE;
        endcase
    end

    // end_cut wins over the limit, so a timeout only latches when it is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in     <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_to     <= 1'b0;
            r_digest <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_in   <= input_data;
                        r_cnt  <= '0;
                        r_to   <= 1'b0;
                        r_hold <= '0;
                    end
                end
                S_LOAD: begin
                    r_hold <= r_hold + 32'd1;
                    r_cnt  <= '0;
                end
                S_RUN: begin
                    if (!end_cut) begin
                        if (w_at_limit)
                            r_to <= 1'b1;
                        else if (r_cnt != 32'hFFFF_FFFF)
                            r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_CAPTURE: begin
                    r_digest <= r_to ? '0 : output_from_cut;
                    r_idx    <= '0;
                end
                S_SEND: begin
                    if (w_pop)
                        r_idx <= r_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CUT_RESULT_CRC_EN
    logic [7:0] w_crc;

    cut_crc8 u_crc (
        .clk    (clk),
        .rst_n  (rst),
        .i_clr  (r_state == S_CAPTURE),
        .i_en   (w_pop && (r_idx < LAST_IDX)),
        .i_byte (w_byte),
        .o_crc  (w_crc)
    );
`endif

    // Multi-byte fields go out MSB first
    always_comb begin
        w_byte = 8'h00;
        if (r_idx == 8'd0)
            w_byte = RECORD_HDR;
        else if (r_idx == 8'd1)
            w_byte = {7'b0, r_to};
        else if (r_idx < 8'd6)
            w_byte = 8'(r_cnt >> {8'd5 - r_idx, 3'b000});
        else if (r_idx < DIG_END)
            w_byte = 8'(r_digest >> {DIG_END - 8'd1 - r_idx, 3'b000});
`ifdef CUT_RESULT_CRC_EN
        else
            w_byte = w_crc;
`endif
    end

    assign rst_cut        = (r_state != S_RUN);
    assign input_to_cut   = r_in;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign timeout        = r_to;
    assign bus.byte_valid = w_send;
    assign bus.byte_out   = w_send ? w_byte : 8'h00;

endmodule

// File: doc/cut_result_collector.md
CUT_RESULT_COLLECTOR -- requirements
Module: cut_result_collector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1048576: max RUN cycles before abort.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2: cycles rst_cut is held high in LOAD.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  one-cycle launch request from the autotest FSM.
REQ-006 SHALL have port input_data  in  DATA_WIDTH  test vector to apply.
REQ-007 SHALL have port rst_cut  out  1  active-high reset to the CUT.
REQ-008 SHALL have port input_to_cut  out  DATA_WIDTH  registered copy of input_data.
REQ-009 SHALL have port end_cut  in  1  CUT completion flag, same clock domain.
REQ-010 SHALL have port output_from_cut  in  N  CUT digest; N is a multiple of 8.
REQ-011 SHALL have port byte_rd  in  1  consumer pops the current record byte.
REQ-012 SHALL have port byte_out  out  8  current record byte.
REQ-013 SHALL have port byte_valid  out  1  byte_out is valid.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port done  out  1  one-cycle pulse after the last byte is popped.
REQ-016 SHALL have port timeout  out  1  sticky per run; set on abort, cleared on next start.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RUN, CAPTURE and SEND.
- IDLE->LOAD on start.
- LOAD->RUN after HOLD_CYCLES.
- RUN->CAPTURE on end_cut or timeout.
- CAPTURE->SEND after 1 cycle.
- SEND->IDLE when the last byte is popped.
REQ-018 SHALL in IDLE: rst_cut=1, byte_valid=0; start ignored whenever busy=1.
REQ-019 SHALL in LOAD: latch input_data into input_to_cut on the start cycle, hold rst_cut=1 for HOLD_CYCLES cycles, clear the cycle counter and clear timeout.
REQ-020 SHALL in RUN: drive rst_cut=0; the 32-bit counter starts at 0 on the first RUN cycle and increments each RUN cycle with end_cut=0; it saturates at 32'hFFFFFFFF.
REQ-021 SHALL treat end_cut=1 on the first RUN cycle as a cycle count of 0.
REQ-022 SHALL abort when the count equals TIMEOUT_CYCLES with end_cut=0: set timeout, force the digest field to zero.
REQ-023 SHALL give end_cut priority when end_cut=1 on the count==TIMEOUT_CYCLES cycle; no timeout in that case.
REQ-024 SHALL in CAPTURE: register output_from_cut and the count, then drive rst_cut=1 again.
REQ-025 SHALL in SEND: present the record in this order:
- 8'hA5;
- status {7'b0, timeout};
- cycle count, 4 bytes, MSB first;
- digest, N/8 bytes, MSB first.
REQ-026 SHALL assert byte_valid in SEND; byte_rd with byte_valid=1 advances byte_out on the next cycle; byte_rd with byte_valid=0 is ignored.
REQ-027 SHALL pulse done in the cycle after the final pop and enter IDLE that same cycle; byte_valid is 0 in that cycle.
REQ-028 SHALL impose no timeout on SEND; the consumer may stall indefinitely.

Reset
REQ-029 SHALL on rst=0, in any state including mid-run, immediately force:
- IDLE;
- rst_cut=1;
- input_to_cut=0, byte_out=0;
- byte_valid=0, busy=0, done=0, timeout=0;
- counter and byte index 0.

Configuration
REQ-030 SHALL, with CUT_RESULT_CRC_EN defined, append one byte after the digest: CRC-8 (poly 8'h07, init 8'h00, MSB-first) over all preceding record bytes; record length 7+N/8.
REQ-031 SHALL, without CUT_RESULT_CRC_EN, end the record after the digest (record length 6+N/8) and instantiate no CRC logic.

Structure
REQ-032 SHALL take DATA_WIDTH and N from package configuration; that package SHALL also hold the state enum typedef, the constant RECORD_HDR=8'hA5 and the CRC polynomial constant.
REQ-033 SHALL place the CRC in sub-module cut_crc8 (byte-in, enable, clear, crc-out), instantiated only under CUT_RESULT_CRC_EN.

Verification
REQ-034 SHALL cover a normal run: input_data=all-ones, end_cut raised 37 cycles after rst_cut falls, digest all-A5 -> record A5,00,00,00,00,25,A5...; done pulses once.
REQ-035 SHALL cover timeout: TIMEOUT_CYCLES=100, end_cut held 0 -> timeout=1, record A5,01,00,00,00,64, digest zeros, rst_cut returns to 1.
REQ-036 SHALL cover immediate end: end_cut=1 before rst_cut falls -> count field 00000000.
REQ-037 SHALL cover consumer stall and mid-run events:
- byte_rd held 0 for 500 cycles in SEND -> byte_out stable on the header, byte_valid=1.
- start pulsed during RUN -> ignored.
REQ-038 SHALL cover reset mid-RUN: rst=0 at count 10 -> all outputs at reset values within the same cycle; a following start gives a fresh count from 0.
REQ-039 SHALL cover CRC: with CUT_RESULT_CRC_EN, the final byte equals a reference CRC-8 of the record; without it, record length is 6+N/8.
